regfile_wport_arb: RTL and testbench

Arbiter and sequencer for the single register-file write port shared by the ALU writeback path (requester A) and the load/memory writeback path (requester B). Each requester has a one-entry holding buffer with a valid/ready handshake. The block grants the port round-robin and drives a registered write enable, address and data. It also drives the `sel` control for the external 5-bit address / 32-bit data 2:1 write-port muxes.

---
 rtl/regfile_wport_arb_if.sv | 46 ++++
 rtl/regfile_wport_arb.sv | 144 ++++++++++++++
 tb/tb_regfile_wport_arb.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wport_arb_if.sv
// Bundle of the two writeback requester handshakes, the stall control and the
// registered register-file write port driven by regfile_wport_arb.
interface regfile_wport_arb_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    // Requester A (ALU writeback)
    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;

    // Requester B (load / memory writeback)
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;

    // Write-port freeze
    logic          stall;

    // Register-file write port and mux select
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          sel;
    logic          busy;

    // Arbiter side of the bundle
    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  stall,
        output a_ready, b_ready,
        output we, waddr, wdata, sel, busy
    );

    // Requester / register-file side of the bundle
    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output stall,
        input  a_ready, b_ready,
        input  we, waddr, wdata, sel, busy
    );
endinterface

// File: rtl/regfile_wport_arb.sv
// Round-robin arbiter for the single register-file write port shared by the
// ALU writeback path (A) and the load writeback path (B). Each source has a
// one-entry holding buffer; writes to register 0 are swallowed at accept time.
module regfile_wport_arb #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wport_arb_if.slave  bus
);

    // Source identifiers for the last-granted pointer and the mux select
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Holding buffers
    logic          r_aFull;
    logic [AW-1:0] r_aAddr;
    logic [DW-1:0] r_aData;
    logic          r_bFull;
    logic [AW-1:0] r_bAddr;
    logic [DW-1:0] r_bData;

    // Round-robin pointer: source granted most recently
    logic          r_last;

    // Registered write port
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;
    logic          r_sel;

    // Combinational grant / handshake terms
    logic          w_aGrant;
    logic          w_bGrant;
    logic          w_grantAny;
    logic          w_aReady;
    logic          w_bReady;
    logic          w_aAccept;
    logic          w_bAccept;
    logic          w_aLoad;
    logic          w_bLoad;

    // Grant: a lone full buffer wins outright; on a tie the source opposite
    // the last grant wins; stall suppresses everything
    always_comb begin
        w_aGrant   = 1'b0;
        w_bGrant   = 1'b0;
        if (!bus.stall) begin
            if (r_aFull && r_bFull) begin
                w_aGrant = (r_last == SRC_B);
                w_bGrant = (r_last == SRC_A);
            end else begin
                w_aGrant = r_aFull;
                w_bGrant = r_bFull;
            end
        end
        w_grantAny = w_aGrant | w_bGrant;
    end

    // Handshake: a buffer being drained this cycle can take a new entry on
    // the same edge, so back-to-back writes from one source have no bubble.
    // Register-0 requests complete the handshake but never load the buffer.
    always_comb begin
        w_aReady  = !r_aFull | w_aGrant;
        w_bReady  = !r_bFull | w_bGrant;
        w_aAccept = bus.a_valid & w_aReady;
        w_bAccept = bus.b_valid & w_bReady;
        w_aLoad   = w_aAccept & (bus.a_addr != '0);
        w_bLoad   = w_bAccept & (bus.b_addr != '0);
    end

    // Buffer A: load on accept (takes priority over the clear from a grant)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aFull <= 1'b0;
            r_aAddr <= '0;
            r_aData <= '0;
        end else if (w_aLoad) begin
            r_aFull <= 1'b1;
            r_aAddr <= bus.a_addr;
            r_aData <= bus.a_data;
        end else if (w_aGrant) begin
            r_aFull <= 1'b0;
        end
    end

    // Buffer B: load on accept (takes priority over the clear from a grant)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bFull <= 1'b0;
            r_bAddr <= '0;
            r_bData <= '0;
        end else if (w_bLoad) begin
            r_bFull <= 1'b1;
            r_bAddr <= bus.b_addr;
            r_bData <= bus.b_data;
        end else if (w_bGrant) begin
            r_bFull <= 1'b0;
        end
    end

    // Round-robin pointer follows every grant; resets to B so A wins the
    // first tie after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= SRC_B;
        end else if (w_grantAny) begin
            r_last <= w_bGrant ? SRC_B : SRC_A;
        end
    end

    // Write-port register: pulse we for each grant, hold address/data/select
    // between grants so the external muxes stay quiet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_sel   <= SRC_A;
        end else begin
            r_we <= w_grantAny;
            if (w_bGrant) begin
                r_waddr <= r_bAddr;
                r_wdata <= r_bData;
                r_sel   <= SRC_B;
            end else if (w_aGrant) begin
                r_waddr <= r_aAddr;
                r_wdata <= r_aData;
                r_sel   <= SRC_A;
            end
        end
    end

    assign bus.a_ready = w_aReady;
    assign bus.b_ready = w_bReady;
    assign bus.we      = r_we;
    assign bus.waddr   = r_waddr;
    assign bus.wdata   = r_wdata;
    assign bus.sel     = r_sel;
    assign bus.busy    = r_aFull | r_bFull | r_we;

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Self-checking bench for regfile_wport_arb: per-source scoreboard queues are
// filled as requests are driven and drained whenever the write port fires.
module tb_regfile_wport_arb;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst_n;

    regfile_wport_arb_if #(.DW(32), .AW(5)) bus ();

    regfile_wport_arb #(.DW(32), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int  total = 0;
    int  bad   = 0;
    bit  sbEnable = 1'b1;
    wr_t qA[$];
    wr_t qB[$];

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every write issued must match the oldest pending entry of
    // the source named by sel, and must never target register 0
    always @(negedge clk) begin
        if (rst_n && sbEnable && bus.we) begin
            wr_t exp;
            total++;
            if (bus.sel && qB.size() == 0) begin
                bad++;
                $display("[TB] FAIL sb_unexpected_B: got addr=%0d data=%h, required no write", bus.waddr, bus.wdata);
            end else if (!bus.sel && qA.size() == 0) begin
                bad++;
                $display("[TB] FAIL sb_unexpected_A: got addr=%0d data=%h, required no write", bus.waddr, bus.wdata);
            end else begin
                exp = bus.sel ? qB.pop_front() : qA.pop_front();
                if (bus.waddr !== exp.addr || bus.wdata !== exp.data) begin
                    bad++;
                    $display("[TB] FAIL sb_write_%s: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.sel ? "B" : "A", bus.waddr, bus.wdata, exp.addr, exp.data);
                end
            end
        end
    end

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.a_valid = 1'b0;
        bus.a_addr  = '0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_addr  = '0;
        bus.b_data  = '0;
        bus.stall   = 1'b0;
    endtask

    task automatic applyReset();
        idleInputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        qA.delete();
        qB.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        applyReset();
        @(negedge clk);
        total++;
        if (bus.we !== 1'b0 || bus.waddr !== 5'd0 || bus.wdata !== 32'd0 || bus.sel !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got we=%b waddr=%0d wdata=%h sel=%b busy=%b, required all 0",
                     bus.we, bus.waddr, bus.wdata, bus.sel, bus.busy);
        end
        total++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_ready: got a_ready=%b b_ready=%b, required 1 1", bus.a_ready, bus.b_ready);
        end
    endtask

    task automatic test_single_write();
        applyReset();
        nextCycle();
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd3;
        bus.a_data  = 32'hDEADBEEF;
        qA.push_back('{5'd3, 32'hDEADBEEF});
        @(negedge clk);
        total++;
        if (bus.a_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_ready_c0: got %b, required 1", bus.a_ready);
        end
        nextCycle();
        bus.a_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.we !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_c1: got we=%b busy=%b, required we=0 busy=1", bus.we, bus.busy);
        end
        nextCycle();
        @(negedge clk);
        total++;
        if (bus.we !== 1'b1 || bus.waddr !== 5'd3 || bus.wdata !== 32'hDEADBEEF || bus.sel !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_c2: got we=%b waddr=%0d wdata=%h sel=%b, required 1 3 deadbeef 0",
                     bus.we, bus.waddr, bus.wdata, bus.sel);
        end
        nextCycle();
        @(negedge clk);
        total++;
        if (bus.we !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_c3: got we=%b busy=%b, required 0 0", bus.we, bus.busy);
        end
    endtask

    task automatic test_tie();
        applyReset();
        nextCycle();
        bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'h11;
        bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 32'h22;
        qA.push_back('{5'd5, 32'h11});
        qB.push_back('{5'd7, 32'h22});
        nextCycle();
        idleInputs();
        @(negedge clk);
        total++;
        if (bus.b_ready !== 1'b0 || bus.a_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL tie_ready_c1: got a_ready=%b b_ready=%b, required 1 0", bus.a_ready, bus.b_ready);
        end
        nextCycle();
        @(negedge clk);
        total++;
        if (bus.we !== 1'b1 || bus.sel !== 1'b0 || bus.waddr !== 5'd5) begin
            bad++;
            $display("[TB] FAIL tie_c2: got we=%b sel=%b waddr=%0d, required 1 0 5", bus.we, bus.sel, bus.waddr);
        end
        nextCycle();
        @(negedge clk);
        total++;
        if (bus.we !== 1'b1 || bus.sel !== 1'b1 || bus.waddr !== 5'd7) begin
            bad++;
            $display("[TB] FAIL tie_c3: got we=%b sel=%b waddr=%0d, required 1 1 7", bus.we, bus.sel, bus.waddr);
        end
        nextCycle();
    endtask

    task automatic test_sustained();
        int aNum = 0;
        int bNum = 0;
        applyReset();
        for (int k = 0; k < 14; k++) begin
            nextCycle();
            bus.a_valid = (k < 10);
            bus.a_addr  = 5'((aNum % 31) + 1);
            bus.a_data  = 32'h1000_0000 + 32'(aNum);
            bus.b_valid = (k < 10);
            bus.b_addr  = 5'(((bNum + 10) % 31) + 1);
            bus.b_data  = 32'h2000_0000 + 32'(bNum);
            @(negedge clk);
            if (bus.a_valid && bus.a_ready) begin
                qA.push_back('{bus.a_addr, bus.a_data});
                aNum++;
            end
            if (bus.b_valid && bus.b_ready) begin
                qB.push_back('{bus.b_addr, bus.b_data});
                bNum++;
            end
            if (k >= 2 && k <= 12) begin
                total++;
                if (bus.we !== 1'b1 || bus.sel !== 1'(k % 2)) begin
                    bad++;
                    $display("[TB] FAIL sustained_c%0d: got we=%b sel=%b, required we=1 sel=%0d", k, bus.we, bus.sel, k % 2);
                end
            end else if (k == 13) begin
                total++;
                if (bus.we !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL sustained_drain: got we=%b, required 0", bus.we);
                end
            end
        end
        idleInputs();
        total++;
        if (aNum != 6 || bNum != 5) begin
            bad++;
            $display("[TB] FAIL sustained_accepts: got A=%0d B=%0d, required A=6 B=5", aNum, bNum);
        end
    endtask

    task automatic test_reg0();
        nextCycle();
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd0;
        bus.a_data  = 32'hFFFFFFFF;
        @(negedge clk);
        total++;
        if (bus.a_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reg0_handshake: got a_ready=%b, required 1", bus.a_ready);
        end
        for (int k = 1; k <= 3; k++) begin
            nextCycle();
            bus.a_valid = 1'b0;
            @(negedge clk);
            total++;
            if (bus.we !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reg0_c%0d: got we=%b busy=%b, required 0 0", k, bus.we, bus.busy);
            end
        end
        nextCycle();
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd9;
        bus.a_data  = 32'h0000_0099;
        qA.push_back('{5'd9, 32'h0000_0099});
        nextCycle();
        bus.a_valid = 1'b0;
        nextCycle();
        @(negedge clk);
        total++;
        if (bus.we !== 1'b1 || bus.waddr !== 5'd9) begin
            bad++;
            $display("[TB] FAIL reg0_followup: got we=%b waddr=%0d, required 1 9", bus.we, bus.waddr);
        end
        nextCycle();
    endtask

    task automatic test_stall();
        applyReset();
        nextCycle();
        bus.stall   = 1'b1;
        bus.a_valid = 1'b1; bus.a_addr = 5'd12; bus.a_data = 32'hAAAA_0001;
        bus.b_valid = 1'b1; bus.b_addr = 5'd13; bus.b_data = 32'hBBBB_0002;
        qA.push_back('{5'd12, 32'hAAAA_0001});
        qB.push_back('{5'd13, 32'hBBBB_0002});
        @(negedge clk);
        total++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL stall_accept_empty: got a_ready=%b b_ready=%b, required 1 1", bus.a_ready, bus.b_ready);
        end
        for (int k = 1; k <= 3; k++) begin
            nextCycle();
            bus.a_valid = 1'b0;
            bus.b_valid = 1'b0;
            @(negedge clk);
            total++;
            if (bus.we !== 1'b0 || bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0 || bus.busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL stall_hold_c%0d: got we=%b a_ready=%b b_ready=%b busy=%b, required 0 0 0 1",
                         k, bus.we, bus.a_ready, bus.b_ready, bus.busy);
            end
        end
        nextCycle();
        bus.stall = 1'b0;
        @(negedge clk);
        total++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_release_grant: got a_ready=%b b_ready=%b, required 1 0", bus.a_ready, bus.b_ready);
        end
        nextCycle();
        @(negedge clk);
        total++;
        if (bus.we !== 1'b1 || bus.sel !== 1'b0) begin
            bad++;
            $display("[TB] FAIL stall_first: got we=%b sel=%b, required 1 0", bus.we, bus.sel);
        end
        nextCycle();
        @(negedge clk);
        total++;
        if (bus.we !== 1'b1 || bus.sel !== 1'b1) begin
            bad++;
            $display("[TB] FAIL stall_second: got we=%b sel=%b, required 1 1", bus.we, bus.sel);
        end
        nextCycle();
    endtask

    task automatic test_mid_reset();
        applyReset();
        sbEnable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            bus.a_valid = 1'b1; bus.a_addr = 5'd2; bus.a_data = 32'(k);
            bus.b_valid = 1'b1; bus.b_addr = 5'd4; bus.b_data = 32'(k + 100);
        end
        @(negedge clk);
        total++;
        if (bus.we !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_traffic: got we=%b, required 1", bus.we);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_async: got we=%b busy=%b a_ready=%b b_ready=%b, required 0 0 1 1",
                     bus.we, bus.busy, bus.a_ready, bus.b_ready);
        end
        idleInputs();
        repeat (2) @(negedge clk);
        qA.delete();
        qB.delete();
        rst_n = 1'b1;
        sbEnable = 1'b1;
        @(negedge clk);
        total++;
        if (bus.we !== 1'b0 || bus.waddr !== 5'd0 || bus.wdata !== 32'd0 || bus.sel !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_release: got we=%b waddr=%0d wdata=%h sel=%b busy=%b, required all 0",
                     bus.we, bus.waddr, bus.wdata, bus.sel, bus.busy);
        end
        nextCycle();
        bus.a_valid = 1'b1; bus.a_addr = 5'd21; bus.a_data = 32'h5A5A_5A5A;
        qA.push_back('{5'd21, 32'h5A5A_5A5A});
        nextCycle();
        bus.a_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.we !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_early: got we=%b, required 0", bus.we);
        end
        nextCycle();
        @(negedge clk);
        total++;
        if (bus.we !== 1'b1 || bus.waddr !== 5'd21) begin
            bad++;
            $display("[TB] FAIL midreset_first_write: got we=%b waddr=%0d, required 1 21", bus.we, bus.waddr);
        end
        nextCycle();
    endtask

    initial begin
        idleInputs();
        rst_n = 1'b0;
        test_reset();
        test_single_write();
        test_tie();
        test_sustained();
        test_reg0();
        test_stall();
        test_mid_reset();
        repeat (2) nextCycle();
        total++;
        if (qA.size() != 0 || qB.size() != 0) begin
            bad++;
            $display("[TB] FAIL sb_leftover: got A=%0d B=%0d pending, required 0 0", qA.size(), qB.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
